nn_layer_sequencer: RTL and testbench
=====================================

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameters: NODES, default 16, number of vu_activation lanes in the array; DRAIN, default NODES-1, number of cycles for the last input to reach the final lane.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to run a network.
- n_in0  in  5  input count of layer 0, legal 1..16.
- n_hid  in  5  input count of every later layer (previous layer width), legal 1..16.
- n_layers  in  3  layer count, legal 1..7.
- shift_cfg  in  4  requantisation shift for the array.
- arr_rst  out  1  clears array accumulators.
- x_valid  out  1  a real operand is driven on xin this cycle.
- x_src  out  1  operand source: 0 = external input buffer, 1 = result feedback buffer.
- x_idx  out  4  operand index within the source buffer.
- layer_idx  out  3  current layer, used for weight bank selection.
- output_layer  out  1  last layer active.
- shift  out  4  array shift.
- capture  out  1  results must be latched into the feedback buffer.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-start pulse.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, CAPTURE.
REQ-004 IDLE: start with legal n_in0, n_hid and n_layers SHALL latch all configuration inputs, set layer_idx=0 and go to CLEAR; configuration inputs are ignored after this cycle until the next start.
REQ-005 IDLE: start with any field at 0 or >16 (n_layers 0) SHALL pulse err for 1 cycle in the following cycle and remain in IDLE.
REQ-006 start SHALL be ignored while busy; no err is raised in that case.
REQ-007 CLEAR SHALL last exactly 1 cycle with arr_rst=1, then go to FEED.
REQ-008 FEED SHALL last N cycles, where N=n_in0 for layer 0 and N=n_hid otherwise.
REQ-009 In FEED, x_valid=1 and x_idx SHALL run 0..N-1, one step per cycle.
REQ-010 In FEED, x_src SHALL be 0 for layer 0 and 1 for later layers.
REQ-011 DRAIN SHALL last DRAIN cycles with x_valid=0 and x_idx=0; the upstream mux SHALL drive xin=0 whenever x_valid=0.
REQ-012 CAPTURE SHALL last 1 cycle with capture=1.
REQ-013 After CAPTURE, if layer_idx < n_layers-1: layer_idx SHALL increment and the FSM SHALL go to CLEAR; otherwise it SHALL go to IDLE.
REQ-014 done SHALL be 1 during the CAPTURE cycle of the last layer only.
REQ-015 Per-layer latency SHALL be N+DRAIN+2 cycles.
REQ-016 There SHALL be no idle cycle between layers.
REQ-017 output_layer SHALL be 1 whenever layer_idx == n_layers-1 and busy=1.
REQ-018 shift SHALL equal the latched shift_cfg while busy and hold its last value in IDLE.
REQ-019 busy SHALL be 1 in every non-IDLE state.
REQ-020 All outputs SHALL be registered (Moore), with no combinational path from inputs to outputs.
REQ-021 Counters SHALL be 5 bits for the FEED/DRAIN count and 3 bits for layers; no wrap-around SHALL be reachable with legal configuration.

Reset
REQ-022 reset SHALL immediately force IDLE.
REQ-023 Under reset, all outputs SHALL be 0 except arr_rst=1, so the array is cleared for the whole reset.
REQ-024 Reset SHALL clear counters, layer_idx and all latched configuration.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence without emitting done or capture.
REQ-026 The first start is accepted on the first clock edge after reset deasserts.

Verification
REQ-027 Single layer: n_in0=4, n_layers=1, start at cycle 0 -> arr_rst at cycle 1; x_valid at cycles 2-5 with x_idx 0,1,2,3 and x_src=0; DRAIN at cycles 6-20; capture=done=output_layer=1 at cycle 21; busy=0 at cycle 22.
REQ-028 Three layers: n_in0=16, n_hid=8, n_layers=3 -> layer 0 occupies 33 cycles, layers 1 and 2 occupy 25 cycles each; x_src=1 from layer 1 onward; output_layer=1 only during layer 2; exactly one done, at cycle 83.
REQ-029 Illegal configuration: n_in0=0 or n_in0=17 -> err pulse at cycle 1, busy stays 0.
REQ-030 Start during FEED: second start pulse -> ignored; timing identical to REQ-027.
REQ-031 Reset during DRAIN of layer 1 -> outputs go to reset values immediately; no done; a subsequent start runs cleanly from layer 0.
REQ-032 shift_cfg changed mid-run -> shift holds the value latched at start for the whole sequence.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for a systolic activation array: steps each layer through
// clear, operand feed, pipeline drain and result capture, for 1..7 layers.
module nn_layer_sequencer #(
    parameter int unsigned NODES = 16,
    parameter int unsigned DRAIN = NODES - 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] n_in0,
    input  logic [4:0] n_hid,
    input  logic [2:0] n_layers,
    input  logic [3:0] shift_cfg,
    output logic       arr_rst,
    output logic       x_valid,
    output logic       x_src,
    output logic [3:0] x_idx,
    output logic [2:0] layer_idx,
    output logic       output_layer,
    output logic [3:0] shift,
    output logic       capture,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CW = 5;
    localparam int unsigned LW = 3;
    localparam int unsigned MAX_IN = 16;
    localparam logic [CW-1:0] DRAIN_LAST = (DRAIN == 0) ? CW'(0) : CW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cfg_n_in0;
    logic [CW-1:0] cfg_n_hid;
    logic [LW-1:0] cfg_layers;

    logic          cfg_legal;
    logic [CW-1:0] feed_len;
    logic          last_layer;
    logic          next_is_last;

    // Configuration check and per-layer derived values
    always_comb begin
        cfg_legal    = (n_in0 != '0) && (n_in0 <= CW'(MAX_IN)) &&
                       (n_hid != '0) && (n_hid <= CW'(MAX_IN)) &&
                       (n_layers != '0);
        feed_len     = (layer_idx == '0) ? cfg_n_in0 : cfg_n_hid;
        last_layer   = (layer_idx == cfg_layers - LW'(1));
        next_is_last = (LW'(layer_idx + LW'(1)) == cfg_layers - LW'(1));
    end

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cfg_n_in0    <= '0;
            cfg_n_hid    <= '0;
            cfg_layers   <= '0;
            arr_rst      <= 1'b1;
            x_valid      <= 1'b0;
            x_src        <= 1'b0;
            x_idx        <= '0;
            layer_idx    <= '0;
            output_layer <= 1'b0;
            shift        <= '0;
            capture      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            arr_rst <= 1'b0;
            x_valid <= 1'b0;
            x_idx   <= '0;
            capture <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            cfg_n_in0    <= n_in0;
                            cfg_n_hid    <= n_hid;
                            cfg_layers   <= n_layers;
                            shift        <= shift_cfg;
                            layer_idx    <= '0;
                            output_layer <= (n_layers == LW'(1));
                            x_src        <= 1'b0;
                            arr_rst      <= 1'b1;
                            busy         <= 1'b1;
                            cnt          <= '0;
                            state        <= S_CLEAR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    cnt     <= '0;
                    x_valid <= 1'b1;
                    x_idx   <= '0;
                    x_src   <= (layer_idx != '0);
                    state   <= S_FEED;
                end

                S_FEED: begin
                    if (cnt == feed_len - CW'(1)) begin
                        cnt <= '0;
                        if (DRAIN == 0) begin
                            capture <= 1'b1;
                            done    <= last_layer;
                            state   <= S_CAPTURE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        cnt     <= cnt + CW'(1);
                        x_valid <= 1'b1;
                        x_idx   <= 4'(cnt + CW'(1));
                    end
                end

                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        cnt     <= '0;
                        capture <= 1'b1;
                        done    <= last_layer;
                        state   <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_CAPTURE: begin
                    if (!last_layer) begin
                        layer_idx    <= layer_idx + LW'(1);
                        output_layer <= next_is_last;
                        arr_rst      <= 1'b1;
                        state        <= S_CLEAR;
                    end else begin
                        output_layer <= 1'b0;
                        x_src        <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: cycle-exact checks of layer timing,
// illegal starts, ignored restarts, shift latching and mid-run reset.
module tb_nn_layer_sequencer;

    localparam int DRAIN_CYC = 15;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] n_in0;
    logic [4:0] n_hid;
    logic [2:0] n_layers;
    logic [3:0] shift_cfg;
    logic       arr_rst;
    logic       x_valid;
    logic       x_src;
    logic [3:0] x_idx;
    logic [2:0] layer_idx;
    logic       output_layer;
    logic [3:0] shift;
    logic       capture;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    nn_layer_sequencer #(.NODES(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .n_in0(n_in0), .n_hid(n_hid), .n_layers(n_layers), .shift_cfg(shift_cfg),
        .arr_rst(arr_rst), .x_valid(x_valid), .x_src(x_src), .x_idx(x_idx),
        .layer_idx(layer_idx), .output_layer(output_layer), .shift(shift),
        .capture(capture), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and checks every cycle against the layer timing model.
    // restart_at: cycle at which a second start is driven (0 = none).
    // chg_at: cycle at which all config inputs are scrambled (0 = none).
    task automatic run_seq(input int n0, input int nh, input int nl,
                           input int sh, input int restart_at, input int chg_at);
        int total;
        int dones;
        n_in0     = 5'(n0);
        n_hid     = 5'(nh);
        n_layers  = 3'(nl);
        shift_cfg = 4'(sh);
        start     = 1'b1;
        total     = 0;
        dones     = 0;
        for (int l = 0; l < nl; l++) total += ((l == 0) ? n0 : nh) + DRAIN_CYC + 2;
        for (int c = 1; c <= total + 1; c++) begin
            int s, lay, o, n, len;
            bit found;
            step();
            start = 1'b0;
            if (c == restart_at) start = 1'b1;
            if (c == chg_at) begin
                shift_cfg = 4'(~sh);
                n_in0     = 5'd3;
                n_hid     = 5'd2;
                n_layers  = 3'd7;
            end
            s = 1; found = 0; lay = 0; o = 0; n = 0;
            for (int l = 0; l < nl; l++) begin
                int ln = (l == 0) ? n0 : nh;
                len = ln + DRAIN_CYC + 2;
                if (!found && c >= s && c < s + len) begin
                    found = 1; lay = l; o = c - s; n = ln;
                end
                s += len;
            end
            if (done) dones++;
            check("err", int'(err), 0);
            if (found) begin
                bit xv;
                xv = (o >= 1) && (o <= n);
                check("busy", int'(busy), 1);
                check("arr_rst", int'(arr_rst), int'(o == 0));
                check("x_valid", int'(x_valid), int'(xv));
                check("x_idx", int'(x_idx), xv ? o - 1 : 0);
                if (xv) check("x_src", int'(x_src), int'(lay != 0));
                check("layer_idx", int'(layer_idx), lay);
                check("output_layer", int'(output_layer), int'(lay == nl - 1));
                check("capture", int'(capture), int'(o == n + DRAIN_CYC + 1));
                check("done", int'(done), int'((o == n + DRAIN_CYC + 1) && (lay == nl - 1)));
                check("shift", int'(shift), sh);
            end else begin
                check("idle_busy", int'(busy), 0);
                check("idle_arr_rst", int'(arr_rst), 0);
                check("idle_capture", int'(capture), 0);
                check("idle_output_layer", int'(output_layer), 0);
                check("idle_shift_hold", int'(shift), sh);
            end
        end
        check("done_count", dones, 1);
        start = 1'b0;
    endtask

    task automatic illegal_start(input int n0, input int nh, input int nl, input string tag);
        n_in0    = 5'(n0);
        n_hid    = 5'(nh);
        n_layers = 3'(nl);
        start    = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_err"}, int'(err), 1);
        check({tag, "_busy"}, int'(busy), 0);
        step();
        check({tag, "_err_clear"}, int'(err), 0);
        check({tag, "_busy2"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        n_in0 = '0; n_hid = '0; n_layers = '0; shift_cfg = '0;
        step();
        check("rst_arr_rst", int'(arr_rst), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_x_valid", int'(x_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_layer_idx", int'(layer_idx), 0);
        check("rst_shift", int'(shift), 0);
        @(negedge clk);
        reset = 1'b0;

        // Single layer, accepted on first edge after reset release
        run_seq(4, 1, 1, 5, 0, 0);
        // Three layers
        run_seq(16, 8, 3, 9, 0, 0);
        // Illegal configurations
        illegal_start(0, 4, 1, "n_in0_0");
        illegal_start(17, 4, 1, "n_in0_17");
        illegal_start(4, 0, 2, "n_hid_0");
        illegal_start(4, 4, 0, "n_layers_0");
        // Restart during FEED is ignored
        run_seq(4, 1, 1, 3, 3, 0);
        // Config changed mid-run, including shift_cfg
        run_seq(2, 16, 2, 6, 0, 10);
        // Minimum and maximum sizes
        run_seq(1, 1, 7, 15, 0, 0);

        // Reset during DRAIN of layer 1 (16/8/3: layer 1 drain is cycles 43..57)
        n_in0 = 5'd16; n_hid = 5'd8; n_layers = 3'd3; shift_cfg = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 50; c++) step();
        check("pre_abort_layer", int'(layer_idx), 1);
        check("pre_abort_x_valid", int'(x_valid), 0);
        check("pre_abort_busy", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_arr_rst", int'(arr_rst), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_capture", int'(capture), 0);
        check("abort_done", int'(done), 0);
        check("abort_layer", int'(layer_idx), 0);
        check("abort_shift", int'(shift), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_hold_done", int'(done), 0);
            check("abort_hold_arr_rst", int'(arr_rst), 1);
        end
        @(negedge clk);
        reset = 1'b0;
        run_seq(4, 1, 1, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
